// File: rtl/fetch_pkg.sv
// Shared widths, default memory latency and FSM state encoding for the
// instruction-fetch line controller.
package fetch_pkg;
    localparam int LINE_BITS           = 128;
    localparam int WORD_BITS           = 32;
    localparam int TAG_BITS            = 28;
    localparam int DEFAULT_MEM_LATENCY = 7;

    typedef enum logic {
        READY = 1'b0,
        FILL  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_line_controller_line_buffer.sv
// Single-line instruction buffer: tag/valid/line registers, hit compare and
// word-select mux. A clear takes priority over a simultaneous load.
module line_buffer
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [TAG_BITS-1:0]  load_tag,
    input  logic [LINE_BITS-1:0] load_line,
    input  logic [TAG_BITS-1:0]  lookup_tag,
    input  logic [1:0]           word_sel,
    output logic                 tag_match,
    output logic [WORD_BITS-1:0] word
);
    logic [LINE_BITS-1:0] buf_line;
    logic [TAG_BITS-1:0]  buf_tag;
    logic                 buf_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_line  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_line  <= load_line;
            buf_tag   <= load_tag;
            buf_valid <= 1'b1;
        end
    end

    assign tag_match = buf_valid && (buf_tag == lookup_tag);
    // Byte 0 of the line sits in the LSBs, so word k is bits [32k +: 32].
    assign word      = buf_line[WORD_BITS*int'(word_sel) +: WORD_BITS];
endmodule

// File: rtl/fetch_line_controller.sv
// IF-stage fetch controller: serves 32-bit words from one buffered line and
// refills it from a fixed-latency instruction memory on a miss.
module fetch_line_controller
    import fetch_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc,
    input  logic                 fetch_req,
    input  logic                 inv,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 stall,
    output logic [31:0]          mem_addr,
    input  logic [LINE_BITS-1:0] mem_line,
    output logic [CNT_W-1:0]     miss_count,
    output fetch_state_t         fsm_state
);
    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);

    fetch_state_t          state;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [WORD_BITS-1:0]  word;
    logic                  tag_match;
    logic                  hit;
    logic                  start_fill;
    logic                  capture;
    logic                  pc_unused;

    assign pc_tag    = pc[31:4];
    assign pc_unused = ^pc[1:0];
    assign hit       = tag_match && (state == READY);

    // A redirect in FILL restarts exactly like a fresh miss; inv suppresses both.
    assign start_fill = !inv && fetch_req &&
                        (((state == READY) && !hit) ||
                         ((state == FILL) && (pc_tag != fill_tag)));
    assign capture    = !inv && (state == FILL) && !start_fill && (wait_cnt == '0);

    line_buffer u_line_buffer (
        .clk        (clk),
        .reset      (reset),
        .clear      (inv),
        .load       (capture),
        .load_tag   (fill_tag),
        .load_line  (mem_line),
        .lookup_tag (pc_tag),
        .word_sel   (pc[3:2]),
        .tag_match  (tag_match),
        .word       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= READY;
            fill_tag   <= '0;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            miss_count <= '0;
        end else if (inv) begin
            state <= READY;
        end else if (start_fill) begin
            state    <= FILL;
            fill_tag <= pc_tag;
            mem_addr <= {pc_tag, 4'h0};
            wait_cnt <= WAIT_W'(MEM_LATENCY);
            if (miss_count != '1) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end else if (state == FILL) begin
            if (wait_cnt == '0) begin
                state <= READY;
            end else begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
        end
    end

    assign instr_valid = fetch_req && hit;
    assign instr       = instr_valid ? word : '0;
    assign stall       = fetch_req && !instr_valid;
    assign fsm_state   = state;
endmodule
